// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer: fixed-select by default, round-robin
// arbitration when ROUND_ROBIN_EN is defined. One beat per cycle, latency 1.
module stream_mux_rr #(
  parameter int WIDTH = 16,
  parameter int CH    = 16,
  parameter int SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_chan,
  output logic                out_valid,
  input  logic                out_ready
);

  // Handshake: a beat moves on any port only when its valid and ready are both
  // high in the same cycle; valid never waits on ready.
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_chan_q, out_chan_d;
  logic              load_en;
  logic              xfer;
  logic              grant_valid;
  logic [SELW-1:0]   grant_idx;
  logic [CH-1:0]     grant;

`ifdef ROUND_ROBIN_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            unused_sel;

  assign unused_sel = ^sel;

  // First valid channel strictly above ptr, otherwise the lowest valid one.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < CH; i++) begin
      if (!grant_valid && in_valid[i] && (i > int'(ptr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(i);
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (!grant_valid && in_valid[i]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SELW'(CH - 1);
    else        ptr_q <= ptr_d;
  end
`else
  // Out-of-range selects simply never grant.
  always_comb begin
    grant_idx   = sel;
    grant_valid = 1'b0;
    if (int'(sel) < CH) grant_valid = in_valid[sel];
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  // rst_n gates load_en so in_ready stays low throughout reset.
  assign load_en  = rst_n & (~out_valid_q | out_ready);
  assign xfer     = load_en & grant_valid;
  assign in_ready = {CH{load_en}} & grant;

  always_comb begin
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_data_d = in_data[grant_idx*WIDTH +: WIDTH];
      out_chan_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr; follows ROUND_ROBIN_EN to pick the
// arbitration rules of its reference model.
module tb_stream_mux_rr;

  localparam int WIDTH = 16;
`ifdef ROUND_ROBIN_EN
  localparam int CH = 4;
`else
  localparam int CH = 12;
`endif
  localparam int SELW = $clog2(CH);
  localparam int EW   = SELW + WIDTH;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_chan;
  logic                out_valid;
  logic                out_ready;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            model_full = 1'b0;
  int            model_ptr  = CH - 1;

  stream_mux_rr #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: which channel the spec's arbitration rules pick, or -1.
  function automatic int pick_channel(input logic [CH-1:0] v, input logic [SELW-1:0] s, input int ptr);
`ifdef ROUND_ROBIN_EN
    for (int i = 1; i <= CH; i++)
      if (v[(ptr + i) % CH]) return (ptr + i) % CH;
    return -1;
`else
    if (int'(s) < CH && v[s]) return int'(s);
    return -1;
`endif
  endfunction

  // Model: predicts in_ready and out_valid, records every accepted beat.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      model_full = 1'b0;
      model_ptr  = CH - 1;
      exp_q.delete();
      check("reset_in_ready", 64'(in_ready), 64'(0));
      check("reset_out_valid", 64'(out_valid), 64'(0));
    end else begin
      int g;
      bit ld;
      logic [CH-1:0] exp_rdy;
      ld = !model_full || out_ready;
      g = pick_channel(in_valid, sel, model_ptr);
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(model_full));
      if (ld && g >= 0) begin
        exp_q.push_back({SELW'(g), in_data[g*WIDTH +: WIDTH]});
        model_ptr  = g;
        model_full = 1'b1;
      end else if (out_ready) begin
        model_full = 1'b0;
      end
    end
  end

  // Monitor: every consumed beat must be the oldest expected one.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(1), 64'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
        check("out_chan", 64'(out_chan), 64'(e[EW-1:WIDTH]));
      end
    end
  end

  task automatic pattern_data();
    for (int k = 0; k < CH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(16'h3f00 + k);
  endtask

  task automatic random_data();
    for (int k = 0; k < CH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic drive(input logic [CH-1:0] v, input logic [SELW-1:0] s, input logic r);
    in_valid  = v;
    sel       = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    logic [WIDTH-1:0] held;
    #2 rst_n = 1'b0;
    #1;
    held = out_data;
    check("async_out_valid", 64'(out_valid), 64'(0));
    check("async_out_data", 64'(held), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    sel = '0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_data", 64'(out_data), 64'(0));
    check("reset_out_chan", 64'(out_chan), 64'(0));
    rst_n = 1'b1;
    pattern_data();

`ifdef ROUND_ROBIN_EN
    repeat (5) drive('1, '0, 1'b1);
    repeat (4) drive(CH'(4'b1010), '0, 1'b1);
    drive('0, '0, 1'b1);
    drive(CH'(4'b0100), '0, 1'b0);
    repeat (2) drive(CH'(4'b0100), '0, 1'b0);
    drive(CH'(4'b1100), '0, 1'b1);
    drive('0, '0, 1'b1);
    drive('1, '0, 1'b1);
    mid_reset();
    drive('1, '0, 1'b1);
    drive('1, '0, 1'b1);
`else
    drive('1, SELW'(0), 1'b1);
    drive('1, SELW'(1), 1'b1);
    drive('1, SELW'(6), 1'b1);
    drive('1, SELW'(11), 1'b1);
    drive('1, SELW'(3), 1'b0);
    drive('1, SELW'(5), 1'b0);
    drive('1, SELW'(7), 1'b0);
    drive('1, SELW'(9), 1'b1);
    drive('1, SELW'(13), 1'b0);
    drive('1, SELW'(13), 1'b1);
    drive('1, SELW'(13), 1'b1);
    drive('1, SELW'(2), 1'b1);
    mid_reset();
    drive('1, SELW'(4), 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      random_data();
      if (n == 200) mid_reset();
      drive(CH'($urandom), SELW'($urandom_range(0, (1 << SELW) - 1)),
            1'($urandom_range(0, 3) != 0));
    end

    repeat (4) drive('0, '0, 1'b1);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
